// File: rtl/rseq_pkg.sv
// Shared types and constants for the read-stage sequencer.
package rseq_pkg;
  typedef enum logic {IDLE, BURST} stage_state_e;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned GRP_W      = 6;
endpackage

// File: rtl/read_stage_sequencer_ctrl.sv
// One coefficient-bank stage: turns enable windows into a burst of read addresses,
// counts groups per timestep and raises long/overflow strobes.
module read_stage_ctrl
  import rseq_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned WIN      = 4,
  parameter int unsigned N_GROUPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sta,
  input  logic             ena,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic [GRP_W-1:0] grp_idx,
  output logic             done,
  output logic             long_c,
  output logic             ovf_c
);
  localparam int unsigned BW = $clog2(WIN + 2);
  localparam int unsigned CW = GRP_W + 1;

  stage_state_e  state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [CW-1:0] grp_q, grp_d;
  logic          ena_prev_q, ena_prev_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          done_q, done_d;
  logic [AW-1:0] base_c;

  // Beat counter saturates at WIN+1 so an over-long window reports exactly once.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    grp_d      = grp_q;
    ena_prev_d = ena;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    done_d     = 1'b0;
    long_c     = 1'b0;
    ovf_c      = 1'b0;
    base_c     = AW'(32'(grp_q) * WIN);
    case (state_q)
      IDLE: begin
        if (ena) begin
          if (grp_q < CW'(N_GROUPS)) begin
            state_d = BURST;
            rd_en_d = 1'b1;
            addr_d  = base_c;
            beat_d  = BW'(1);
          end else if (!ena_prev_q) begin
            ovf_c = 1'b1;
          end
        end
      end
      BURST: begin
        if (ena) begin
          if (beat_q < BW'(WIN)) begin
            rd_en_d = 1'b1;
            addr_d  = base_c + AW'(beat_q);
            beat_d  = beat_q + BW'(1);
          end else if (beat_q == BW'(WIN)) begin
            long_c = 1'b1;
            beat_d = BW'(WIN + 1);
          end
        end else begin
          state_d = IDLE;
          beat_d  = '0;
          grp_d   = grp_q + CW'(1);
          done_d  = (grp_q + CW'(1)) == CW'(N_GROUPS);
        end
      end
      default: state_d = IDLE;
    endcase
    // Timestep start overrides any group advance in the same cycle.
    if (sta) begin
      grp_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      grp_q      <= '0;
      ena_prev_q <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      grp_q      <= grp_d;
      ena_prev_q <= ena_prev_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = addr_q;
  assign grp_idx = grp_q[GRP_W-1:0];
  assign done    = done_q;
endmodule

// File: rtl/read_stage_sequencer.sv
// Three-stage read sequencer driven by the staggered ena_read4/8/12 windows.
// Optional RSEQ_ERR_CNT_EN adds a saturating error-event counter output.
module read_stage_sequencer
  import rseq_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned WIN      = 4,
  parameter int unsigned N_GROUPS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sta,
  input  logic                  ena_read4,
  input  logic                  ena_read8,
  input  logic                  ena_read12,
  output logic [NUM_STAGES-1:0] rd_en,
  output logic [AW-1:0]         rd_addr0,
  output logic [AW-1:0]         rd_addr1,
  output logic [AW-1:0]         rd_addr2,
  output logic [GRP_W-1:0]      grp_idx,
  output logic                  frame_done,
  output logic                  err_long,
`ifdef RSEQ_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic                  err_ovf
);
  logic [NUM_STAGES-1:0] ena_s;
  logic [NUM_STAGES-1:0] rd_en_s;
  logic [NUM_STAGES-1:0] long_s;
  logic [NUM_STAGES-1:0] ovf_s;
  logic [AW-1:0]         addr_s [NUM_STAGES];
  logic [GRP_W-1:0]      grp_s  [NUM_STAGES];
  logic                  done_s [NUM_STAGES];
  logic                  err_long_q, err_long_d;
  logic                  err_ovf_q, err_ovf_d;

  assign ena_s = {ena_read12, ena_read8, ena_read4};

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    read_stage_ctrl #(
      .AW      (AW),
      .WIN     (WIN),
      .N_GROUPS(N_GROUPS)
    ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .sta    (sta),
      .ena    (ena_s[k]),
      .rd_en  (rd_en_s[k]),
      .rd_addr(addr_s[k]),
      .grp_idx(grp_s[k]),
      .done   (done_s[k]),
      .long_c (long_s[k]),
      .ovf_c  (ovf_s[k])
    );
  end

  // Sticky error flags, cleared at timestep start.
  always_comb begin
    err_long_d = err_long_q | (|long_s);
    err_ovf_d  = err_ovf_q | (|ovf_s);
    if (sta) begin
      err_long_d = 1'b0;
      err_ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_long_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      err_long_q <= err_long_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

`ifdef RSEQ_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [8:0] err_sum_c;

  // Every strobe counts, so simultaneous events across stages/kinds each add one.
  always_comb begin
    err_sum_c = {1'b0, err_cnt_q} + 9'($countones({long_s, ovf_s}));
    err_cnt_d = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
    if (sta) err_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign rd_en      = rd_en_s;
  assign rd_addr0   = addr_s[0];
  assign rd_addr1   = addr_s[1];
  assign rd_addr2   = addr_s[2];
  assign grp_idx    = grp_s[NUM_STAGES-1];
  assign frame_done = done_s[NUM_STAGES-1];
  assign err_long   = err_long_q;
  assign err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_read_stage_sequencer.sv
// Scoreboard bench for read_stage_sequencer: window-level reference model feeds
// per-stage expectation queues; a negedge monitor pops and compares.
module tb_read_stage_sequencer;
  localparam int unsigned AW  = 10;
  localparam int unsigned WIN = 4;
  localparam int unsigned NG  = 2;

  logic          clk = 1'b0;
  logic          rst_n, sta, ena_read4, ena_read8, ena_read12;
  logic [2:0]    rd_en;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2;
  logic [5:0]    grp_idx;
  logic          frame_done, err_long, err_ovf;
`ifdef RSEQ_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  read_stage_sequencer #(.AW(AW), .WIN(WIN), .N_GROUPS(NG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sta       (sta),
    .ena_read4 (ena_read4),
    .ena_read8 (ena_read8),
    .ena_read12(ena_read12),
    .rd_en     (rd_en),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .grp_idx   (grp_idx),
    .frame_done(frame_done),
    .err_long  (err_long),
`ifdef RSEQ_ERR_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cy;
    int addr;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  int   fd_seen = 0, frame_m = 0, long_m = 0, ovf_m = 0;
  int   grp_m [3];
  int   nwin [3];
  int   len_tab [3][320];
  int   max_gap = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int cy, input int addr);
    exp_t e;
    e.cy = cy;
    e.addr = addr;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int addr_of(input int k);
    case (k)
      0: return int'(rd_addr0);
      1: return int'(rd_addr1);
      default: return int'(rd_addr2);
    endcase
  endfunction

  task automatic pop_chk(input int k);
    exp_t e;
    bit   have = 1'b0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) chk($sformatf("unexpected_rd_en%0d", k), longint'(rd_en[k]), 0);
    else begin
      chk($sformatf("rd_addr%0d", k), addr_of(k), e.addr);
      chk($sformatf("rd_cycle%0d", k), cyc, e.cy);
    end
  endtask

  // Monitor: every asserted read enable must match the next expected beat.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_seen++;
    for (int k = 0; k < 3; k++)
      if (rd_en[k] === 1'b1) pop_chk(k);
  end

  task automatic set_ena(input int k, input logic v);
    case (k)
      0: ena_read4 = v;
      1: ena_read8 = v;
      default: ena_read12 = v;
    endcase
  endtask

  // Reference model per window: grp*WIN+i for the first min(L,WIN) beats.
  task automatic run_stage(input int k);
    for (int w = 0; w < nwin[k]; w++) begin
      int  len = len_tab[k][w];
      int  gap = $urandom_range(max_gap, 1);
      int  e0;
      bit  acc;
      @(posedge clk);
      #1;
      set_ena(k, 1'b1);
      e0  = cyc + 1;
      acc = grp_m[k] < NG;
      if (acc) begin
        for (int i = 0; i < len && i < WIN; i++)
          push(k, e0 + i, (grp_m[k] * WIN + i) % (1 << AW));
        if (len > WIN) long_m++;
      end else ovf_m++;
      repeat (len) @(posedge clk);
      #1;
      set_ena(k, 1'b0);
      if (acc) begin
        grp_m[k]++;
        if (k == 2 && grp_m[k] == NG) frame_m++;
      end
      repeat (gap - 1) @(posedge clk);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr0"}, rd_addr0, 0);
    chk({tag, "_addr1"}, rd_addr1, 0);
    chk({tag, "_addr2"}, rd_addr2, 0);
    chk({tag, "_grp_idx"}, grp_idx, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_long"}, err_long, 0);
    chk({tag, "_err_ovf"}, err_ovf, 0);
`ifdef RSEQ_ERR_CNT_EN
    chk({tag, "_err_cnt"}, err_cnt, 0);
`endif
  endtask

  task automatic do_sta();
    @(posedge clk);
    #1 sta = 1'b1;
    @(posedge clk);
    #1 sta = 1'b0;
    for (int k = 0; k < 3; k++) grp_m[k] = 0;
    long_m = 0;
    ovf_m  = 0;
    chk("sta_err_long", err_long, 0);
    chk("sta_err_ovf", err_ovf, 0);
    chk("sta_grp_idx", grp_idx, 0);
`ifdef RSEQ_ERR_CNT_EN
    chk("sta_err_cnt", err_cnt, 0);
`endif
  endtask

  task automatic run_all_and_check(input string tag);
    fork
      run_stage(0);
      run_stage(1);
      run_stage(2);
    join
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_err_long"}, err_long, long_m > 0);
    chk({tag, "_err_ovf"}, err_ovf, ovf_m > 0);
    chk({tag, "_grp_idx"}, grp_idx, grp_m[2] % 64);
    chk({tag, "_frame_done_count"}, fd_seen, frame_m);
    chk({tag, "_missing_beats"}, q0.size() + q1.size() + q2.size(), 0);
`ifdef RSEQ_ERR_CNT_EN
    chk({tag, "_err_cnt"}, err_cnt, (long_m + ovf_m > 255) ? 255 : long_m + ovf_m);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n = 1'b0; sta = 1'b0;
    ena_read4 = 1'b1; ena_read8 = 1'b0; ena_read12 = 1'b0;
    for (int k = 0; k < 3; k++) grp_m[k] = 0;

    // Reset with an active window held on stage 0.
    repeat (3) begin
      @(posedge clk);
      #1 check_zero("reset");
    end
    rst_n = 1'b1;
    ena_read4 = 1'b0;
    @(posedge clk);
    #1 check_zero("post_reset");

    // Nominal groups, a 6-beat stage-1 window and a third (overflow) stage-0 window.
    do_sta();
    nwin[0] = 3; nwin[1] = 1; nwin[2] = 2;
    for (int w = 0; w < 3; w++) len_tab[0][w] = 4;
    len_tab[1][0] = 6;
    len_tab[2][0] = 4; len_tab[2][1] = 4;
    max_gap = 1;
    run_all_and_check("directed");

    // Randomized timesteps with overlapping windows on all stages.
    max_gap = 3;
    for (int ep = 0; ep < 8; ep++) begin
      do_sta();
      for (int k = 0; k < 3; k++) begin
        nwin[k] = $urandom_range(3, 0);
        for (int w = 0; w < nwin[k]; w++) len_tab[k][w] = $urandom_range(6, 1);
      end
      run_all_and_check($sformatf("rand%0d", ep));
    end

    // Reset during beat 2 of a stage-2 burst: beats 0,1 only, no frame_done.
    do_sta();
    @(posedge clk);
    #1 ena_read12 = 1'b1;
    e0 = cyc + 1;
    push(2, e0, 0);
    push(2, e0 + 1, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    ena_read12 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midburst_rd_en", rd_en, 0);
    for (int k = 0; k < 3; k++) grp_m[k] = 0;
    nwin[0] = 0; nwin[1] = 0; nwin[2] = 1;
    len_tab[2][0] = 4;
    max_gap = 1;
    run_all_and_check("after_midburst_reset");

`ifdef RSEQ_ERR_CNT_EN
    // 300 overflow windows saturate the error counter.
    do_sta();
    nwin[0] = 302; nwin[1] = 0; nwin[2] = 0;
    for (int w = 0; w < 302; w++) len_tab[0][w] = 1;
    run_all_and_check("err_cnt_sat");
    do_sta();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
